// File: rtl/ahb_txn_capture.sv
// ahb_txn_capture
//   Passive AHB-lite transfer collector for the monitor BFM. It pairs each
//   accepted address phase with its data phase and emits one record per
//   completed transfer: {address, direction, data}. Records are queued in a
//   small FIFO and handed to the consumer over a valid/ready handshake. The
//   block only observes the bus and never drives it.
//
// Ports
//   hclk, hreset         clock, synchronous active-high reset
//   haddr, htrans,       observed AHB-lite address phase
//   hwrite, hready
//   hwdata, hrdata       observed data phase (write / read data)
//   txn_valid/txn_ready  record handshake
//   txn_addr/write/data  head-of-queue record
//   fill                 FIFO occupancy, 0..DEPTH
//   overflow             sticky flag, set on the first dropped record
//   drop_cnt             saturating count of dropped records
module ahb_txn_capture #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [ADDR_W-1:0]        haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [DATA_W-1:0]        hwdata,
    input  logic [DATA_W-1:0]        hrdata,
    input  logic                     hready,
    output logic                     txn_valid,
    input  logic                     txn_ready,
    output logic [ADDR_W-1:0]        txn_addr,
    output logic                     txn_write,
    output logic [DATA_W-1:0]        txn_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int REC_W  = ADDR_W + 1 + DATA_W;
    localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic                write_r, write_nxt_s;
    logic                acc_s;
    logic                push_s;
    logic [REC_W-1:0]    rec_s;

    logic [REC_W-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [FILL_W-1:0]   fill_r;
    logic                overflow_r;
    logic [CNT_W-1:0]    drop_cnt_r;
    logic                full_s;
    logic                pop_s;
    logic                wr_en_s;
    logic                drop_s;
    logic                valid_s;
    logic [REC_W-1:0]    head_s;

    // Only NONSEQ/SEQ transfers with hready high start a new address phase.
    assign acc_s = hready & htrans[1];

    // Address/data phase pairing: next state, captured address and record push.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        write_nxt_s = write_r;
        push_s      = 1'b0;
        rec_s       = {addr_r, write_r, (write_r ? hwdata : hrdata)};
        case (state_r)
            ST_IDLE: begin
                if (acc_s) begin
                    state_nxt_s = ST_PEND;
                    addr_nxt_s  = haddr;
                    write_nxt_s = hwrite;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (hready) begin
                    push_s = 1'b1;
                    // Pipelined bus: the next address phase overlaps this data phase.
                    if (acc_s) begin
                        state_nxt_s = ST_PEND;
                        addr_nxt_s  = haddr;
                        write_nxt_s = hwrite;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pairing state registers.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            write_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            write_r <= write_nxt_s;
        end
    end

    assign valid_s = (fill_r != {FILL_W{1'b0}});
    assign full_s  = (fill_r == FULL_LVL);
    assign pop_s   = valid_s & txn_ready;
    // A full queue still takes the push when the head leaves in the same cycle.
    assign wr_en_s = push_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    // Record storage; contents are only visible through the valid-gated head.
    always_ff @(posedge hclk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= rec_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Queue pointers, occupancy and drop accounting.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fill_r     <= {FILL_W{1'b0}};
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (wr_en_s && !pop_s) begin
                fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
            end else if (pop_s && !wr_en_s) begin
                fill_r <= fill_r - {{(FILL_W-1){1'b0}}, 1'b1};
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != {CNT_W{1'b1}}) begin
                    drop_cnt_r <= drop_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Head record is zero while the queue is empty so reset shows all-zero outputs.
    assign head_s    = valid_s ? mem_r[rd_ptr_r] : {REC_W{1'b0}};
    assign txn_valid = valid_s;
    assign txn_addr  = head_s[REC_W-1 -: ADDR_W];
    assign txn_write = head_s[DATA_W];
    assign txn_data  = head_s[DATA_W-1:0];
    assign fill      = fill_r;
    assign overflow  = overflow_r;
    assign drop_cnt  = drop_cnt_r;

endmodule
